mmio_console_responder: RTL and testbench

//  Memory-mapped console responder on the core's data-memory port (memory_io_req/memory_io_rsp).

---
 rtl/mmio_console_responder_if.sv | 27 ++
 rtl/mmio_console_responder.sv | 231 +++++++++++++++++++++++
 tb/tb_mmio_console_responder.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_console_responder_if.sv
// Data-memory port bundle between the core (master) and a memory-mapped
// responder (slave).
//
// Handshake: a request is presented for exactly one cycle with req_valid=1
// and is always accepted (no ready, no backpressure). A responder that
// claims the request raises rsp_valid for exactly one cycle, one cycle
// later, echoing the request address. rsp_valid=0 means "not mine".
interface mmio_console_responder_if;
  logic        req_valid;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [3:0]  req_do_read;
  logic [3:0]  req_do_write;
  logic        rsp_valid;
  logic [31:0] rsp_addr;
  logic [31:0] rsp_data;

  modport master (
    output req_valid, req_addr, req_data, req_do_read, req_do_write,
    input  rsp_valid, rsp_addr, rsp_data
  );

  modport slave (
    input  req_valid, req_addr, req_data, req_do_read, req_do_write,
    output rsp_valid, rsp_addr, rsp_data
  );
endinterface

// File: rtl/mmio_console_responder.sv
// Console window at the top of data space: STATUS / TXDATA / HALT registers,
// a byte FIFO feeding an 8N1 serialiser, and a sticky halt that waits for
// the line to drain.
module mmio_console_responder #(
  parameter logic [31:0] BASE_ADDR    = 32'h0002_FFF0,
  parameter int          FIFO_DEPTH   = 16,
  parameter int          CLKS_PER_BIT = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  mmio_console_responder_if.slave  mem,
  output logic                     tx,
  output logic                     halt,
  output logic [1:0]               dbg_state_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // Request decode
  logic        hit;
  logic        is_read;
  logic        is_write;
  logic [1:0]  reg_off;
  logic        push_req;
  logic        halt_wr;
  logic        status_rd;
  logic        unused_bits;

  // FIFO
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push_ok;
  logic          pop;

  // Serialiser
  tx_state_e     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          baud_end;

  // Control / status
  logic        overflow_q, overflow_d;
  logic        halt_pending_q, halt_pending_d;
  logic        halt_q, halt_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_addr_q, rsp_addr_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic [31:0] status_word;
  logic [31:0] read_data;

  assign hit = mem.req_valid
            && (mem.req_addr[31:4] == BASE_ADDR[31:4])
            && ((mem.req_do_read != 4'd0) || (mem.req_do_write != 4'd0));
  assign is_read   = hit && (mem.req_do_read != 4'd0);
  assign is_write  = hit && (mem.req_do_write != 4'd0);
  assign reg_off   = mem.req_addr[3:2];
  assign push_req  = is_write && (reg_off == 2'd2) && mem.req_do_write[0];
  assign halt_wr   = is_write && (reg_off == 2'd3);
  assign status_rd = is_read && (reg_off == 2'd0);

  // Byte lanes above TXDATA[7:0] and the sub-word address bits carry no meaning here.
  assign unused_bits = ^{mem.req_data[31:8], mem.req_addr[1:0]};

  assign fifo_full  = (count_q == COUNT_FULL);
  assign fifo_empty = (count_q == '0);
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push_ok    = push_req && (!fifo_full || pop);
  assign baud_end   = (baud_q == BAUD_LAST);

  // FIFO pointer/count next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_ok && !pop)      count_d = count_q + CW'(1);
    else if (!push_ok && pop) count_d = count_q - CW'(1);
  end

  // FIFO storage; contents need no reset because the count gates every read
  always_ff @(posedge clk) begin
    if (push_ok) fifo_q[wr_ptr_q] <= mem.req_data[7:0];
  end

  // Serialiser next-state: start bit, 8 data bits LSB first, stop bit
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_q[rd_ptr_q];
          baud_d  = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      ST_DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = ST_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      ST_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          // Chain straight into the next frame so there is no idle gap.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_q[rd_ptr_q];
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Line level follows the state directly, so reset returns it high at once
  always_comb begin
    tx = 1'b1;
    case (state_q)
      ST_START: tx = 1'b0;
      ST_DATA:  tx = shift_q[0];
      default:  tx = 1'b1;
    endcase
  end

  // Register read mux and control/response next-state
  always_comb begin
    status_word        = 32'd0;
    status_word[0]     = fifo_full;
    status_word[1]     = fifo_empty;
    status_word[2]     = (state_q != ST_IDLE);
    status_word[3]     = overflow_q;
    status_word[4]     = halt_pending_q;
    status_word[15:8]  = 8'(count_q);

    read_data = 32'd0;
    if (reg_off == 2'd0) read_data = status_word;

    rsp_valid_d = hit;
    rsp_addr_d  = hit ? mem.req_addr : 32'd0;
    rsp_data_d  = is_read ? read_data : 32'd0;

    // A drop in the same cycle as a STATUS read wins, so the event is not lost.
    overflow_d = overflow_q;
    if (push_req && !push_ok) overflow_d = 1'b1;
    else if (status_rd)       overflow_d = 1'b0;

    halt_pending_d = halt_pending_q | halt_wr;
    halt_d = halt_q | (halt_pending_q && fifo_empty && (state_q == ST_IDLE));
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      state_q        <= ST_IDLE;
      baud_q         <= '0;
      bit_q          <= 3'd0;
      shift_q        <= 8'd0;
      overflow_q     <= 1'b0;
      halt_pending_q <= 1'b0;
      halt_q         <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_addr_q     <= 32'd0;
      rsp_data_q     <= 32'd0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      state_q        <= state_d;
      baud_q         <= baud_d;
      bit_q          <= bit_d;
      shift_q        <= shift_d;
      overflow_q     <= overflow_d;
      halt_pending_q <= halt_pending_d;
      halt_q         <= halt_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_addr_q     <= rsp_addr_d;
      rsp_data_q     <= rsp_data_d;
    end
  end

  assign mem.rsp_valid = rsp_valid_q;
  assign mem.rsp_addr  = rsp_addr_q;
  assign mem.rsp_data  = rsp_data_q;
  assign halt          = halt_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_mmio_console_responder.sv
// Bench for the console responder: randomized bus traffic against a
// transaction-level model (byte queue plus "transmitter busy for one frame
// per byte"), and a UART receiver on the tx line that checks each decoded
// byte against the queue of bytes the model says were sent.
module tb_mmio_console_responder;

  localparam logic [31:0] BASE  = 32'h0002_FFF0;
  localparam int          DEPTH = 16;
  localparam int          CPB   = 4;
  localparam int          FRAME = 10 * CPB;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mmio_console_responder_if bus ();
  logic       tx;
  logic       halt;
  logic [1:0] dbg_state;

  mmio_console_responder #(
    .BASE_ADDR   (BASE),
    .FIFO_DEPTH  (DEPTH),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mem        (bus.slave),
    .tx         (tx),
    .halt       (halt),
    .dbg_state_o(dbg_state)
  );

  initial begin
    #(200000 * 10);
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1);
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  m_q[$];      // bytes waiting in the FIFO
  logic [7:0]  exp_q[$];    // bytes handed to the line, awaiting the receiver
  bit          m_ovf, m_hp, m_halt;
  int          e_n = 0;     // index of the next clock edge driven through cycle()
  int          last_pop = 0;
  bit          popped_any = 0;
  bit          m_rsp_valid;
  logic [31:0] m_rsp_addr, m_rsp_data;

  // A byte taken at edge p keeps the transmitter busy until it may take the next at p+FRAME.
  function automatic bit busy_at(int e);
    return popped_any && (e <= last_pop + FRAME);
  endfunction

  function automatic bit can_take(int e);
    return !popped_any || (e >= last_pop + FRAME);
  endfunction

  task automatic model_reset();
    m_q.delete();
    exp_q.delete();
    m_ovf = 0; m_hp = 0; m_halt = 0;
    popped_any = 0;
  endtask

  task automatic model_edge(input bit v, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] rd, input logic [3:0] wr);
    bit          hit;
    int          off;
    logic [31:0] st;
    bit          drop;
    hit  = v && ((a >> 4) == (BASE >> 4)) && (rd != 0 || wr != 0);
    off  = int'((a >> 2) & 32'd3);
    drop = 0;
    st = 32'd0;
    st[15:8] = 8'(m_q.size());
    st[4] = m_hp;
    st[3] = m_ovf;
    st[2] = busy_at(e_n);
    st[1] = (m_q.size() == 0);
    st[0] = (m_q.size() == DEPTH);
    m_rsp_valid = hit;
    m_rsp_addr  = a;
    m_rsp_data  = (hit && rd != 0 && off == 0) ? st : 32'd0;
    if (m_hp && m_q.size() == 0 && !busy_at(e_n)) m_halt = 1;
    if (m_q.size() > 0 && can_take(e_n)) begin
      exp_q.push_back(m_q.pop_front());
      last_pop   = e_n;
      popped_any = 1;
    end
    if (hit && off == 2 && wr[0]) begin
      if (m_q.size() < DEPTH) m_q.push_back(d[7:0]);
      else drop = 1;
    end
    if (drop) m_ovf = 1;
    else if (hit && rd != 0 && off == 0) m_ovf = 0;
    if (hit && off == 3 && wr != 0) m_hp = 1;
    e_n++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input bit v, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] rd, input logic [3:0] wr);
    bus.req_valid    = v;
    bus.req_addr     = a;
    bus.req_data     = d;
    bus.req_do_read  = rd;
    bus.req_do_write = wr;
    @(posedge clk);
    model_edge(v, a, d, rd, wr);
    #1;
    check_eq("rsp_valid", bus.rsp_valid, m_rsp_valid);
    if (m_rsp_valid) check_eq("rsp_addr", bus.rsp_addr, m_rsp_addr);
    check_eq("rsp_data", bus.rsp_data, m_rsp_data);
    check_eq("halt", halt, m_halt);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 32'd0, 32'd0, 4'd0, 4'd0);
  endtask

  task automatic wr_reg(input logic [31:0] a, input logic [31:0] d, input logic [3:0] wr);
    cycle(1, a, d, 4'd0, wr);
  endtask

  task automatic rd_reg(input logic [31:0] a);
    cycle(1, a, 32'd0, 4'hF, 4'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 2000; i++) begin
      if (m_q.size() == 0 && !busy_at(e_n) && exp_q.size() == 0) break;
      idle(1);
    end
    idle(4);
    check_eq("drain_empty", exp_q.size(), 0);
  endtask

  // ---------------- serial receiver (scoreboard consumer) ----------------
  bit         mon_active = 0;
  int         mon_cnt = 0;
  logic [7:0] mon_byte;
  int         rx_count = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        mon_active = 0;
      end else if (!mon_active) begin
        if (tx == 1'b0) begin
          mon_active = 1;
          mon_cnt    = 0;
        end
      end else begin
        mon_cnt++;
        for (int i = 0; i < 8; i++)
          if (mon_cnt == (i + 1) * CPB + CPB / 2) mon_byte[i] = tx;
        if (mon_cnt == 9 * CPB + CPB / 2) begin
          mon_active = 0;
          rx_count++;
          check_eq("rx_stop", tx, 1);
          check_eq("rx_pending", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) check_eq("rx_byte", mon_byte, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [9:0]  t2_bits = 10'b10_1000_0010;  // level k of the 0x41 frame at bit k
  int          rx_before;
  logic [31:0] a;
  logic [3:0]  rd, wr;
  int          sel;

  initial begin
    bus.req_valid = 0; bus.req_addr = 0; bus.req_data = 0;
    bus.req_do_read = 0; bus.req_do_write = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_tx", tx, 1);
    check_eq("rst_halt", halt, 0);
    check_eq("rst_rsp_valid", bus.rsp_valid, 0);
    check_eq("rst_rsp_data", bus.rsp_data, 0);
    @(negedge clk);
    reset = 1;

    // Reset release: STATUS shows only fifo_empty
    rd_reg(BASE);
    check_eq("t1_status", bus.rsp_data, 32'h0000_0002);
    check_eq("t1_addr", bus.rsp_addr, 32'h0002_FFF0);

    // Single byte 'A' and its exact line waveform
    wr_reg(32'h0002_FFF8, 32'h41, 4'b0001);
    check_eq("t2_wr_valid", bus.rsp_valid, 1);
    check_eq("t2_wr_data", bus.rsp_data, 0);
    for (int k = 0; k < FRAME; k++) begin
      idle(1);
      check_eq("t2_tx", tx, t2_bits[k / CPB]);
    end
    drain();
    check_eq("t2_tx_idle", tx, 1);

    // Address decode just outside the window
    rd_reg(32'h0002_FFEC);
    check_eq("t5_rd_valid", bus.rsp_valid, 0);
    cycle(1, 32'h0003_0000, 32'h55, 4'd0, 4'hF);
    check_eq("t5_wr_valid", bus.rsp_valid, 0);
    rd_reg(BASE);
    check_eq("t5_status", bus.rsp_data, 32'h0000_0002);

    // Overflow: one byte goes to the line, then 17 writes against a busy line
    rx_before = rx_count;
    wr_reg(BASE + 8, $urandom_range(0, 255), 4'b0001);
    idle(2);
    for (int i = 0; i < 17; i++) wr_reg(BASE + 8, $urandom_range(0, 255), 4'b0001);
    rd_reg(BASE);
    check_eq("t3_ovf_set", (bus.rsp_data >> 3) & 1, 1);
    check_eq("t3_full", bus.rsp_data & 1, 1);
    check_eq("t3_count", (bus.rsp_data >> 8) & 32'hFF, DEPTH);
    rd_reg(BASE);
    check_eq("t3_ovf_clr", (bus.rsp_data >> 3) & 1, 0);
    drain();
    check_eq("t3_frames", rx_count - rx_before, 17);

    // Halt waits for "Hi" to leave the line
    wr_reg(BASE + 8, 32'h48, 4'b0001);
    wr_reg(BASE + 8, 32'h69, 4'b0001);
    wr_reg(BASE + 12, 32'h0, 4'b1000);
    check_eq("t4_halt_early", halt, 0);
    drain();
    idle(5);
    check_eq("t4_halt_sticky", halt, 1);

    // Randomized traffic around and inside the window
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 7);
      if (sel <= 3)      a = BASE + 32'(sel * 4);
      else if (sel == 4) a = BASE + 8;
      else if (sel == 5) a = BASE - 32'($urandom_range(1, 4) * 4);
      else if (sel == 6) a = BASE + 16 + 32'($urandom_range(0, 3) * 4);
      else               a = BASE;
      a  = a + 32'($urandom_range(0, 3));
      rd = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      wr = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      cycle($urandom_range(0, 3) != 0, a, $urandom, rd, wr);
    end
    drain();

    // Reset in the middle of data bit 3 of 0xF0 (bit 3 is a 0 on the line)
    wr_reg(BASE + 8, 32'hF0, 4'b0001);
    for (int i = 0; i < 100 && e_n != last_pop + 4 * CPB + 2; i++) idle(1);
    check_eq("t6_state_data", dbg_state, 2);
    check_eq("t6_tx_bit3", tx, 0);
    rx_before = rx_count;
    reset = 0;
    #1;
    check_eq("t6_tx_high", tx, 1);
    check_eq("t6_halt_clr", halt, 0);
    check_eq("t6_rsp_valid", bus.rsp_valid, 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1;
    rd_reg(BASE);
    check_eq("t6_status", bus.rsp_data, 32'h0000_0002);
    for (int i = 0; i < 2 * FRAME; i++) begin
      idle(1);
      check_eq("t6_tx_quiet", tx, 1);
    end
    check_eq("t6_no_frames", rx_count - rx_before, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
